buffer_fill_drain_ctrl: RTL and testbench

Controller directly upstream of the per-row 16-bit FIFO buffers that feed the systolic array. Accepts ARR_SIZE-lane packed words from the external interface over a valid/ready handshake and fans each lane out to its row buffer. Drives each buffer's 2-bit state code: 01 = enqueue, 10 = dequeue, 00 = idle. Once a batch is loaded, it issues row-skewed dequeue commands so that row i starts draining i cycles after row 0, which gives the diagonal wavefront the array requires.

---
 rtl/buffer_pkg.sv | 21 ++
 rtl/buffer_fill_drain_ctrl.sv | 138 +++++++++++++
 tb/tb_buffer_fill_drain_ctrl.sv | 175 +++++++++++++++++
 3 files changed

// File: rtl/buffer_pkg.sv
// Shared types for the row-buffer fill/drain controller.
package buffer_pkg;

  // Width of one row buffer word.
  localparam int LANE_W = 16;

  // Per-row buffer command code.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_LOAD  = 2'b01,
    ST_DRAIN = 2'b10
  } lane_state_e;

  // Controller phase.
  typedef enum logic [1:0] {
    IDLE,
    FILL,
    DRAIN
  } ctrl_fsm_e;

endpackage

// File: rtl/buffer_fill_drain_ctrl.sv
// Loads a batch of packed words into the per-row buffers, then drains them
// with row i starting i cycles after row 0 to form the diagonal wavefront.
module buffer_fill_drain_ctrl
  import buffer_pkg::*;
#(
  parameter int ARR_SIZE    = 4,
  parameter int QUEUE_DEPTH = 2 * ARR_SIZE,
  parameter int CNT_W       = $clog2(QUEUE_DEPTH) + 1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       start,
  input  logic [LANE_W*ARR_SIZE-1:0] in_data,
  input  logic                       in_valid,
  input  logic                       in_last,
  output logic                       in_ready,
  output logic [LANE_W*ARR_SIZE-1:0] lane_data,
  output logic [2*ARR_SIZE-1:0]      lane_state,
  output logic [CNT_W-1:0]           batch_count,
  output logic                       busy,
  output logic                       done
);

  // Drain counter must reach QUEUE_DEPTH + ARR_SIZE - 1.
  localparam int DRAIN_W = $clog2(QUEUE_DEPTH + ARR_SIZE) + 1;
  localparam logic [CNT_W-1:0]   DEPTH_C   = CNT_W'(QUEUE_DEPTH);
  localparam logic [DRAIN_W-1:0] SKEW_SPAN = DRAIN_W'(ARR_SIZE - 1);
  localparam logic [1:0]         LOAD_CODE = ST_LOAD;
  localparam logic [1:0]         DRN_CODE  = ST_DRAIN;
  localparam logic [1:0]         IDLE_CODE = ST_IDLE;

  ctrl_fsm_e                  state_reg, state_next;
  logic [CNT_W-1:0]           count_reg, count_next;
  logic [DRAIN_W-1:0]         drain_reg, drain_next;
  logic [2*ARR_SIZE-1:0]      lane_state_reg, lane_state_next;
  logic [LANE_W*ARR_SIZE-1:0] lane_data_reg, lane_data_next;
  logic                       done_reg, done_next;

  logic                       handshake;
  logic [CNT_W-1:0]           count_inc;
  logic                       fill_end;
  logic                       drain_end;
  logic [DRAIN_W-1:0]         words_ext;
  logic [2*ARR_SIZE-1:0]      drain_codes;

  assign in_ready  = (state_reg == FILL) && (count_reg < DEPTH_C);
  assign handshake = in_valid && in_ready;
  assign count_inc = count_reg + 1'b1;
  // Leave FILL on the final accepted word: explicit last, or buffers full.
  assign fill_end  = handshake && (in_last || (count_inc == DEPTH_C));
  assign words_ext = DRAIN_W'(count_reg);
  // Drain spans N + ARR_SIZE - 1 cycles; reaching that count means finished.
  assign drain_end = (drain_reg == (words_ext + SKEW_SPAN));

  // Each lane dequeues while the shared drain counter is inside its window.
  genvar gi;
  generate
    for (gi = 0; gi < ARR_SIZE; gi++) begin : g_skew
      localparam logic [DRAIN_W-1:0] OFFSET = DRAIN_W'(gi);
      logic in_window;
      assign in_window = (drain_reg >= OFFSET) && ((drain_reg - OFFSET) < words_ext);
      assign drain_codes[2*gi+:2] = in_window ? DRN_CODE : IDLE_CODE;
    end
  endgenerate

  // FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_reg <= IDLE;
    else     state_reg <= state_next;
  end

  // Next-state selection.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (start) state_next = FILL;
      FILL:    if (fill_end) state_next = DRAIN;
      DRAIN:   if (drain_end) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Registered output and counter updates for each phase.
  always_comb begin
    count_next      = count_reg;
    drain_next      = drain_reg;
    lane_state_next = '0;
    lane_data_next  = lane_data_reg;
    done_next       = 1'b0;
    case (state_reg)
      IDLE: begin
        if (start) count_next = '0;
      end
      FILL: begin
        drain_next = '0;
        if (handshake) begin
          lane_state_next = {ARR_SIZE{LOAD_CODE}};
          lane_data_next  = in_data;
          count_next      = count_inc;
        end
      end
      DRAIN: begin
        lane_data_next = '0;
        if (drain_end) begin
          done_next = 1'b1;
        end else begin
          lane_state_next = drain_codes;
          drain_next      = drain_reg + 1'b1;
        end
      end
      default: ;
    endcase
  end

  // Datapath registers; reset drops any partial batch.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_reg      <= '0;
      drain_reg      <= '0;
      lane_state_reg <= '0;
      lane_data_reg  <= '0;
      done_reg       <= 1'b0;
    end else begin
      count_reg      <= count_next;
      drain_reg      <= drain_next;
      lane_state_reg <= lane_state_next;
      lane_data_reg  <= lane_data_next;
      done_reg       <= done_next;
    end
  end

  assign lane_state  = lane_state_reg;
  assign lane_data   = lane_data_reg;
  assign batch_count = count_reg;
  assign busy        = (state_reg != IDLE);
  assign done        = done_reg;

endmodule

// File: tb/tb_buffer_fill_drain_ctrl.sv
// Self-checking bench for buffer_fill_drain_ctrl: directed and random batches
// compared cycle by cycle against a batch-level expectation.
module tb_buffer_fill_drain_ctrl;
  import buffer_pkg::*;

  localparam int A  = 4;
  localparam int QD = 2 * A;
  localparam int CW = $clog2(QD) + 1;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              start = 1'b0;
  logic              in_valid = 1'b0;
  logic              in_last = 1'b0;
  logic [16*A-1:0]   in_data = '0;
  logic              in_ready;
  logic [16*A-1:0]   lane_data;
  logic [2*A-1:0]    lane_state;
  logic [CW-1:0]     batch_count;
  logic              busy;
  logic              done;

  int checks = 0;
  int errors = 0;
  logic [16*A-1:0] exp_data = '0;
  int m_count = 0;
  logic [2*A-1:0] load_all;

  buffer_fill_drain_ctrl #(.ARR_SIZE(A), .QUEUE_DEPTH(QD), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .start(start), .in_data(in_data), .in_valid(in_valid),
    .in_last(in_last), .in_ready(in_ready), .lane_data(lane_data),
    .lane_state(lane_state), .batch_count(batch_count), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag, input logic [2*A-1:0] ls, input logic [16*A-1:0] ld,
                           input logic rdy, input logic bsy, input logic dn, input int cnt);
    chk({tag, ".lane_state"}, 64'(lane_state), 64'(ls));
    chk({tag, ".lane_data"}, lane_data, ld);
    chk({tag, ".in_ready"}, 64'(in_ready), 64'(rdy));
    chk({tag, ".busy"}, 64'(busy), 64'(bsy));
    chk({tag, ".done"}, 64'(done), 64'(dn));
    chk({tag, ".batch_count"}, 64'(batch_count), 64'(cnt));
  endtask

  // Lane i dequeues on drain cycles i .. i+n-1.
  function automatic logic [2*A-1:0] drain_code(input int t, input int n);
    logic [2*A-1:0] v;
    v = '0;
    for (int i = 0; i < A; i++)
      if (t >= i && t < i + n) v[2*i+:2] = 2'b10;
    return v;
  endfunction

  // One batch from IDLE: start, fill per mode (0 always valid, 1 alternating,
  // 2 random), then drain; abort_t >= 0 asserts reset at that drain cycle.
  task automatic run_batch(input string name, input int max_words, input bit use_last,
                           input int mode, input bit seq_data, input bit poke, input int abort_t);
    int cyc;
    int n;
    int tally [A];
    bit prev_hs;
    bit ended;
    bit v;
    bit lst;
    bit hold_valid;
    logic [16*A-1:0] d;
    cyc = 0; prev_hs = 0; ended = 0;
    hold_valid = (mode == 0) && !use_last;
    check_all({name, "/idle"}, '0, exp_data, 1'b0, 1'b0, 1'b0, m_count);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    m_count = 0;
    while (!ended) begin
      check_all({name, "/fill"}, prev_hs ? load_all : '0, exp_data, 1'b1, 1'b1, 1'b0, m_count);
      case (mode)
        0: v = 1'b1;
        1: v = (cyc % 2 == 0);
        default: v = 1'($urandom_range(0, 1));
      endcase
      d = {$urandom, $urandom};
      if (seq_data) d[15:0] = 16'(m_count + 1);
      lst = v ? (use_last && (m_count + 1 == max_words)) : 1'($urandom_range(0, 1));
      in_valid = v; in_last = lst; in_data = d;
      start = poke ? 1'($urandom_range(0, 1)) : 1'b0;
      @(negedge clk);
      cyc++;
      prev_hs = v;
      if (v) begin
        m_count++;
        exp_data = d;
        if (lst || m_count == QD) ended = 1;
      end
      if (!ended && cyc > 200) begin
        chk({name, "/fill_timeout"}, 64'(cyc), 64'(0));
        in_valid = 1'b0; start = 1'b0;
        return;
      end
    end
    in_valid = hold_valid; in_last = 1'b0; in_data = {$urandom, $urandom};
    n = m_count;
    for (int i = 0; i < A; i++) tally[i] = 0;
    check_all({name, "/last_load"}, load_all, exp_data, 1'b0, 1'b1, 1'b0, n);
    start = poke ? 1'($urandom_range(0, 1)) : 1'b0;
    exp_data = '0;
    for (int t = 0; t < n + A - 1; t++) begin
      @(negedge clk);
      check_all($sformatf("%s/drain_t%0d", name, t), drain_code(t, n), '0, 1'b0, 1'b1, 1'b0, n);
      for (int i = 0; i < A; i++) if (lane_state[2*i+:2] == 2'b10) tally[i]++;
      start = (poke && t < n + A - 2) ? 1'($urandom_range(0, 1)) : 1'b0;
      if (t == abort_t) begin
        #1 rst = 1'b1;
        #1;
        m_count = 0;
        check_all({name, "/async_rst"}, '0, '0, 1'b0, 1'b0, 1'b0, 0);
        in_valid = 1'b0; start = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        for (int k = 0; k < 3; k++) begin
          @(negedge clk);
          check_all({name, "/post_rst"}, '0, '0, 1'b0, 1'b0, 1'b0, 0);
        end
        return;
      end
    end
    @(negedge clk);
    check_all({name, "/done"}, '0, '0, 1'b0, 1'b0, 1'b1, n);
    for (int i = 0; i < A; i++) chk($sformatf("%s/lane%0d_dequeues", name, i), 64'(tally[i]), 64'(n));
    in_valid = 1'b0;
    @(negedge clk);
    check_all({name, "/after"}, '0, '0, 1'b0, 1'b0, 1'b0, n);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < A; i++) load_all[2*i+:2] = 2'b01;
    @(negedge clk);
    check_all("reset", '0, '0, 1'b0, 1'b0, 1'b0, 0);
    rst = 1'b0;
    @(negedge clk);
    check_all("reset_release", '0, '0, 1'b0, 1'b0, 1'b0, 0);

    run_batch("full8", 8, 1'b0, 0, 1'b1, 1'b0, -1);
    run_batch("last3", 3, 1'b1, 0, 1'b0, 1'b0, -1);
    run_batch("toggle", 4, 1'b1, 1, 1'b1, 1'b0, -1);
    run_batch("abort", 8, 1'b0, 0, 1'b0, 1'b0, 2);
    run_batch("after_rst", 5, 1'b1, 2, 1'b0, 1'b1, -1);
    run_batch("poke", 6, 1'b1, 0, 1'b0, 1'b1, -1);
    run_batch("capacity", 8, 1'b0, 0, 1'b0, 1'b0, -1);
    run_batch("single", 1, 1'b1, 0, 1'b0, 1'b0, -1);
    for (int r = 0; r < 6; r++) begin
      run_batch($sformatf("rand%0d", r), $urandom_range(1, QD), 1'($urandom_range(0, 1)),
                $urandom_range(0, 2), 1'b0, 1'($urandom_range(0, 1)), -1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
